// File: rtl/aes_encrypt_iter_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative encryptor:
//   AES_BLK_W - block width in bits
//   state_t   - 4x4 byte cipher state, indexed [column][row]; column 0 /
//               row 0 is the most significant byte (FIPS-197 byte 0)
//   fsm_t     - encryptor control states
//   SBOX      - forward S-box
//   xtime     - multiply by x in GF(2^8)
//   gmul      - general GF(2^8) multiply
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLK_W = 128;

    // Packed so a 128-bit word casts straight into the cipher state with
    // FIPS-197 byte i landing at column i/4, row i%4.
    typedef logic [0:3][0:3][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } fsm_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x modulo x^8+x^4+x^3+x+1; stays 8 bits wide.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add GF(2^8) multiply built on xtime.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] prod;
        logic [7:0] acc;
        prod = 8'h00;
        acc  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) prod = prod ^ acc;
            acc = xtime(acc);
        end
        return prod;
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_round.sv
// ---------------------------------------------------------------------------
// aes_enc_round
// Purely combinational single AES encryption round.
// Ports:
//   state_in  - current cipher state
//   round_key - round key applied by AddRoundKey
//   final_rnd - 1: last round, MixColumns is skipped
//   state_out - state after SubBytes, ShiftRows, [MixColumns], AddRoundKey
// ---------------------------------------------------------------------------
module aes_enc_round
    import aes_pkg::*;
(
    input  state_t                 state_in,
    input  logic [AES_BLK_W-1:0]   round_key,
    input  logic                   final_rnd,
    output state_t                 state_out
);

    state_t sub_st;
    state_t shift_st;
    state_t mix_st;

    // SubBytes: independent table lookup per byte.
    always_comb begin
        sub_st = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sub_st[c][r] = SBOX[state_in[c][r]];
            end
        end
    end

    // ShiftRows: row r rotates left by r columns, so the byte for column c
    // comes from column (c + r) mod 4 of the same row.
    always_comb begin
        shift_st = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shift_st[c][r] = sub_st[(c + r) % 4][r];
            end
        end
    end

    // MixColumns: each column multiplied by the circulant {02,03,01,01}.
    always_comb begin
        mix_st = '0;
        for (int c = 0; c < 4; c++) begin
            mix_st[c][0] = xtime(shift_st[c][0]) ^ gmul(8'h03, shift_st[c][1])
                         ^ shift_st[c][2] ^ shift_st[c][3];
            mix_st[c][1] = shift_st[c][0] ^ xtime(shift_st[c][1])
                         ^ gmul(8'h03, shift_st[c][2]) ^ shift_st[c][3];
            mix_st[c][2] = shift_st[c][0] ^ shift_st[c][1]
                         ^ xtime(shift_st[c][2]) ^ gmul(8'h03, shift_st[c][3]);
            mix_st[c][3] = gmul(8'h03, shift_st[c][0]) ^ shift_st[c][1]
                         ^ shift_st[c][2] ^ xtime(shift_st[c][3]);
        end
    end

    // The last round of the cipher omits MixColumns before AddRoundKey.
    always_comb begin
        state_out = (final_rnd ? shift_st : mix_st) ^ round_key;
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// aes_encrypt_iter
// Iterative AES encryptor: one cipher round per clock on a shared round
// datapath, plaintext in and ciphertext out over valid/ready handshakes.
// Parameters:
//   NR    - number of rounds (10/12/14 for AES-128/192/256)
//   CNT_W - width of the completed-block counter
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   - plaintext handshake (ready only while IDLE)
//   data_in             - plaintext, FIPS-197 byte 0 in the MSBs
//   key[NR:0]           - expanded round keys; must stay stable from the
//                         accepting edge until out_valid
//   out_valid/out_ready - ciphertext handshake
//   data_out            - ciphertext; keeps the last result after delivery
//   blk_count           - completed-block count (only with the macro below)
// Build option:
//   AES_ENC_BLKCNT_EN   - adds blk_count, counting output handshakes
// ---------------------------------------------------------------------------
module aes_encrypt_iter
    import aes_pkg::*;
#(
    parameter int NR    = 14,
    parameter int CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [AES_BLK_W-1:0]          data_in,
    input  logic [NR:0][AES_BLK_W-1:0]    key,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [AES_BLK_W-1:0]          data_out
`ifdef AES_ENC_BLKCNT_EN
    ,
    output logic [CNT_W-1:0]              blk_count
`endif
);

    localparam int               RND_W    = $clog2(NR + 1);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

    // Reject unsupported configurations at elaboration time.
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_encrypt_iter: NR must be 10, 12 or 14");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("aes_encrypt_iter: CNT_W must be at least 1");
    end

    fsm_t                 fsm_q;
    fsm_t                 fsm_d;
    state_t               state_reg;
    state_t               round_out;
    logic [RND_W-1:0]     rnd;
    logic [AES_BLK_W-1:0] round_key;
    logic                 final_rnd;
    logic                 accept;

    assign accept    = in_valid && in_ready;
    assign final_rnd = (rnd == LAST_RND);
    assign round_key = key[rnd];

    aes_enc_round u_round (
        .state_in  (state_reg),
        .round_key (round_key),
        .final_rnd (final_rnd),
        .state_out (round_out)
    );

    // Control state register; reset drops any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // Next-state and handshake outputs. Requests arriving in the wrong
    // state are simply not acknowledged, so they have no side effect.
    always_comb begin
        fsm_d     = fsm_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_d = ROUND;
            end
            ROUND: begin
                if (final_rnd) fsm_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Round datapath. The initial AddRoundKey is folded into the accepting
    // edge, so rounds 1..NR run on the following NR edges. data_out is a
    // separate register so the ciphertext survives the next block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            rnd       <= '0;
            data_out  <= '0;
        end else if (accept) begin
            state_reg <= data_in ^ key[0];
            rnd       <= RND_W'(1);
        end else if (fsm_q == ROUND) begin
            state_reg <= round_out;
            if (final_rnd) begin
                rnd      <= '0;
                data_out <= round_out;
            end else begin
                rnd <= rnd + RND_W'(1);
            end
        end
    end

`ifdef AES_ENC_BLKCNT_EN
    logic deliver;
    assign deliver = out_valid && out_ready;

    // Counts delivered blocks; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count <= '0;
        end else if (deliver) begin
            blk_count <= blk_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_iter
// Self-checking bench for aes_encrypt_iter (AES-256 build). The reference
// cipher, S-box (from GF inverse + affine map) and key schedule are
// computed here from the cipher definition. Builds with or without
// AES_ENC_BLKCNT_EN.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_iter;

    localparam int NR    = 14;
    localparam int NK    = 8;
    localparam int CNT_W = 32;

    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] RT_KEY = 256'h1212121269696969343434343434343456565656565656567878787878787878;
    localparam logic [127:0] RT_PT  = 128'h1212121234343434ababababcdcdcdcd;

    logic                    clk       = 1'b0;
    logic                    rst_n     = 1'b0;
    logic                    in_valid  = 1'b0;
    logic                    out_ready = 1'b0;
    logic [127:0]            data_in   = '0;
    logic [NR:0][127:0]      key       = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic [127:0]            data_out;
`ifdef AES_ENC_BLKCNT_EN
    logic [CNT_W-1:0]        blk_count;
`endif

    int          n_cmp      = 0;
    int          n_fail     = 0;
    int          cyc        = 0;
    int          handshakes = 0;
    logic [7:0]  sbox_ref [256];

    aes_encrypt_iter #(.NR(NR), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
`ifdef AES_ENC_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b};
        return d[15-k -: 8];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
    endfunction

    function automatic logic [NR:0][127:0] expand_key(input logic [255:0] k);
        logic [31:0]        w [4*(NR+1)];
        logic [31:0]        t;
        logic [7:0]         rcon;
        logic [NR:0][127:0] rk;
        rcon = 8'h01;
        for (int i = 0; i < NK; i++) w[i] = k[255-32*i -: 32];
        for (int i = NK; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gf_mul(rcon, 8'h02);
            end else if (i % NK == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-NK] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [NR:0][127:0] rk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int rd = 1; rd <= NR; rd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_ref[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r + 4*((c + r) % 4)];
            if (rd != NR) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
                    for (int r = 0; r < 4; r++)
                        s[4*c+r] = gf_mul(a[r], 8'h02) ^ gf_mul(a[(r+1)%4], 8'h03)
                                 ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rd][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents a block and returns after the accepting edge.
    task automatic applyStimulus(input logic [127:0] pt, output int acc_cyc);
        int waited;
        data_in  = pt;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            tick();
            waited++;
        end
        checkOutput("in_ready before accept", 128'(in_ready), 128'(1'b1));
        tick();
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic waitOut(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        checkOutput("out_valid within budget", 128'(out_valid), 128'(1'b1));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        handshakes++;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int           lat;
        int           acc;
        int           acc_b [3];
        logic [255:0] k256;
        logic [127:0] pt;
        logic [127:0] ct;

        build_sbox();

        // Reset state
        #23;
        checkOutput("reset in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("reset out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("reset data_out", data_out, 128'h0);
`ifdef AES_ENC_BLKCNT_EN
        checkOutput("reset blk_count", 128'(blk_count), 128'h0);
`endif
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.3 known answer and latency
        key = expand_key(C3_KEY);
        checkOutput("model C.3", aes_ref(C3_PT, key), C3_CT);
        applyStimulus(C3_PT, acc);
        waitOut(lat);
        checkOutput("C.3 latency", 128'(lat), 128'(NR));
        checkOutput("C.3 data_out", data_out, C3_CT);
        checkOutput("in_ready low in DONE", 128'(in_ready), 128'(1'b0));
        handshake();
        checkOutput("after handshake out_valid", 128'(out_valid), 128'(1'b0));
        checkOutput("after handshake in_ready", 128'(in_ready), 128'(1'b1));
        checkOutput("data_out kept", data_out, C3_CT);
`ifdef AES_ENC_BLKCNT_EN
        checkOutput("blk_count after 1", 128'(blk_count), 128'(handshakes));
`endif

        // Second fixed vector against the model
        key = expand_key(RT_KEY);
        applyStimulus(RT_PT, acc);
        waitOut(lat);
        checkOutput("vector 2 data_out", data_out, aes_ref(RT_PT, key));
        handshake();

        // Random keys/plaintexts with random consumer delay
        for (int n = 0; n < 4; n++) begin
            k256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt   = {$urandom, $urandom, $urandom, $urandom};
            key  = expand_key(k256);
            ct   = aes_ref(pt, key);
            applyStimulus(pt, acc);
            waitOut(lat);
            checkOutput("random latency", 128'(lat), 128'(NR));
            repeat ($urandom_range(0, 3)) tick();
            checkOutput("random data_out", data_out, ct);
            handshake();
        end

        // Backpressure: output held, competing input ignored
        pt = {$urandom, $urandom, $urandom, $urandom};
        ct = aes_ref(pt, key);
        applyStimulus(pt, acc);
        waitOut(lat);
        data_in  = ~pt;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("backpressure data_out", data_out, ct);
            checkOutput("backpressure {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'(2'b10));
        end
        in_valid = 1'b0;
        handshake();
        checkOutput("release {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'(2'b01));
        checkOutput("release data_out kept", data_out, ct);
`ifdef AES_ENC_BLKCNT_EN
        checkOutput("blk_count before reset", 128'(blk_count), 128'(handshakes));
`endif

        // Reset during round 7 aborts the block
        pt = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(pt, acc);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'(2'b01));
        checkOutput("abort data_out", data_out, 128'h0);
        handshakes = 0;
`ifdef AES_ENC_BLKCNT_EN
        checkOutput("abort blk_count", 128'(blk_count), 128'h0);
`endif
        #3;
        rst_n = 1'b1;
        tick();
        checkOutput("no output after abort", 128'(out_valid), 128'(1'b0));
        pt = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(pt, acc);
        waitOut(lat);
        checkOutput("post-abort data_out", data_out, aes_ref(pt, key));
        handshake();

        // Back-to-back with consumer always ready
        handshakes = 0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(pt, acc_b[b]);
            waitOut(lat);
            checkOutput("b2b data_out", data_out, aes_ref(pt, key));
            tick();
            handshakes++;
        end
        out_ready = 1'b0;
        checkOutput("b2b interval 1", 128'(acc_b[1] - acc_b[0]), 128'(NR + 2));
        checkOutput("b2b interval 2", 128'(acc_b[2] - acc_b[1]), 128'(NR + 2));
`ifdef AES_ENC_BLKCNT_EN
        checkOutput("b2b blk_count", 128'(blk_count), 128'(3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
